// File: rtl/vga_pkg.sv
// Shared definitions for the VGA image path: default widths and the owner tag
// used by the ROM arbiter, the GPUs and img_vrom.
package vga_pkg;

    localparam int VGA_ADDR_W = 8;
    localparam int VGA_IDX_W  = 3;
    localparam int VGA_DATA_W = 3;

    typedef enum logic {
        OWN_F2 = 1'b0,
        OWN_F3 = 1'b1
    } owner_e;

    // One in-flight ROM read: valid marks a real read, owner routes its data back.
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational. The pointer names
// the requester that wins the next contention and moves only on an accept.
module rr_arb2
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    owner_e ptr;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                gnt = (ptr == OWN_F2) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Priority passes to whichever side did not win the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= OWN_F2;
        end else if (accept) begin
            ptr <= gnt[0] ? OWN_F3 : OWN_F2;
        end
    end

endmodule

// File: rtl/vrom_arbiter.sv
// Shares the image ROM read port between the function-2 and function-3 GPUs.
// It issues reads round-robin and routes tagged ROM data back to the issuer.
module vrom_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W  = VGA_ADDR_W,
    parameter int IDX_W   = VGA_IDX_W,
    parameter int DATA_W  = VGA_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    f2_req,
    input  logic [ADDR_W-1:0]       f2_addr,
    input  logic [IDX_W-1:0]        f2_index,
    output logic                    f2_gnt,
    output logic                    f2_valid,
    output logic [DATA_W-1:0]       f2_data,
    input  logic                    f3_req,
    input  logic [ADDR_W-1:0]       f3_addr,
    input  logic [IDX_W-1:0]        f3_index,
    output logic                    f3_gnt,
    output logic                    f3_valid,
    output logic [DATA_W-1:0]       f3_data,
    output logic                    rom_en,
    output logic [IDX_W+ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic                    busy
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;
    owner_e     issue_owner;
    tag_t       tag_pipe [ROM_LAT];
    tag_t       ret_tag;
    logic       tags_busy;

    assign req    = {f3_req, f2_req};
    assign f2_gnt = gnt[0];
    assign f3_gnt = gnt[1];
    assign accept = |(req & gnt);

    rr_arb2 u_arb (
        .clk    (sysclk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    // Issue stage: the ROM strobe and address are registered on the accept edge.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            issue_owner <= OWN_F2;
        end else begin
            rom_en <= accept;
            if (accept) begin
                rom_addr    <= gnt[1] ? {f3_index, f3_addr} : {f2_index, f2_addr};
                issue_owner <= gnt[1] ? OWN_F3 : OWN_F2;
            end
        end
    end

    // The tag pipe follows the issue stage, so its last stage lines up with rom_data.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_pipe[i] <= '{valid: 1'b0, owner: OWN_F2};
            end
        end else begin
            tag_pipe[0] <= '{valid: rom_en, owner: issue_owner};
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign ret_tag = tag_pipe[ROM_LAT-1];

    always_ff @(posedge sysclk) begin
        if (rst) begin
            f2_valid <= 1'b0;
            f3_valid <= 1'b0;
            f2_data  <= '0;
            f3_data  <= '0;
        end else begin
            f2_valid <= ret_tag.valid && (ret_tag.owner == OWN_F2);
            f3_valid <= ret_tag.valid && (ret_tag.owner == OWN_F3);
            if (ret_tag.valid && (ret_tag.owner == OWN_F2)) begin
                f2_data <= rom_data;
            end
            if (ret_tag.valid && (ret_tag.owner == OWN_F3)) begin
                f3_data <= rom_data;
            end
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) begin
            tags_busy = tags_busy | tag_pipe[i].valid;
        end
    end

    assign busy = rom_en | tags_busy | f2_valid | f3_valid;

endmodule
